// File: rtl/reg_file_wb_pkg.sv
// Shared core definitions: write-back widths plus register-file geometry.
package reg_file_wb_pkg;

  localparam int PC_WIDTH       = 32;
  localparam int WB_DATA_WIDTH  = 32;
  localparam int WB_SEL_WIDTH   = 2;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam int REG_DATA_WIDTH = 32;

  localparam int WR_CNT_WIDTH   = 16;
  localparam int NUM_RD_PORTS   = 2;

  typedef enum logic [0:0] {
    RD_RS = 1'b0,
    RD_RT = 1'b1
  } rd_port_e;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [WR_CNT_WIDTH-1:0] sat_inc(input logic [WR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reg_file_wb_read_port.sv
// One decode read port: zero-register check plus write-first bypass mux.
module reg_read_port
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic is_zero;
  logic hit;

  assign is_zero = (addr == '0);
  // Bypass is gated by reset so a write presented during reset never leaks.
  assign hit     = BYPASS_EN && rst_n && wr_en && (wr_addr == addr);

  always_comb begin
    rd_data = word;
    if (is_zero || !rst_n) rd_data = '0;
    else if (hit)          rd_data = wr_data;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file fed by write-back: 2 decode read ports, 1 debug port.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]   rs_addr,
  input  logic [ADDR_WIDTH-1:0]   rt_addr,
  output logic [DATA_WIDTH-1:0]   rs_data,
  output logic [DATA_WIDTH-1:0]   rt_data,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr,
  output logic [DATA_WIDTH-1:0]   dbg_data,
  output logic [WR_CNT_WIDTH-1:0] wr_count
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   mem_q [NREG];
  logic [WR_CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic                    wr_commit;

  assign wr_commit = wr_en && (wr_addr != '0);

  // Entry 0 is only ever reset, so it reads as the hardwired zero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_commit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit) wr_count_d = sat_inc(wr_count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;

  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  assign rd_addr[RD_RS] = rs_addr;
  assign rd_addr[RD_RT] = rt_addr;

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    reg_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS_EN  (BYPASS_EN)
    ) u_rd (
      .rst_n   (rst_n),
      .addr    (rd_addr[g]),
      .word    (mem_q[rd_addr[g]]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[g])
    );
  end

  assign rs_data = rd_data[RD_RS];
  assign rt_data = rd_data[RD_RT];

  // Debug sees storage only, never the in-flight write.
  assign dbg_data = rst_n ? mem_q[dbg_addr] : '0;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file: the receiving end of the write-back interface.
- Consumes the write-back stage's result, destination and write-enable; stores 32 general-purpose registers.
- Serves two decode-stage read ports plus one debug read port.
- Provides write-first bypass, so a value written back in cycle N is visible to decode in the same cycle N.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers).
- BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding on rs/rt ports; 0 = read storage only.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable from write-back stage.
- wr_addr  input  ADDR_WIDTH  destination register index.
- wr_data  input  DATA_WIDTH  write-back result (ALU/MEM/PC/IMM already selected upstream).
- rs_addr  input  ADDR_WIDTH  read port A index.
- rt_addr  input  ADDR_WIDTH  read port B index.
- rs_data  output  DATA_WIDTH  read port A data.
- rt_data  output  DATA_WIDTH  read port B data.
- dbg_addr  input  ADDR_WIDTH  debug/inspection read index.
- dbg_data  output  DATA_WIDTH  debug read data; never bypassed.
- wr_count  output  16  saturating count of committed register writes since reset.

Behaviour:
- Storage: 2**ADDR_WIDTH words, reg[0] hardwired to zero.
  - Writes to index 0 are discarded.
  - Writes to index 0 do not increment wr_count.
- Reset:
  - rst_n low asynchronously clears every register and wr_count to 0.
  - While rst_n is low, rs_data, rt_data and dbg_data read 0; bypass is gated off.
  - Reset asserted in the same cycle as wr_en: reset wins and no write occurs.
  - First write is accepted on the first rising edge after rst_n deasserts.
- Write:
  - On the rising edge with wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data, and wr_count increments.
  - wr_count saturates at 16'hFFFF; it does not wrap.
  - Latency: the stored value is visible on dbg_data one cycle after the edge.
- Read, combinational, zero latency:
  - rs_data = 0 if rs_addr==0.
  - Otherwise, if BYPASS_EN and rst_n and wr_en and wr_addr==rs_addr: rs_data = wr_data.
  - Otherwise rs_data = reg[rs_addr].
  - rt_data follows the identical rule using rt_addr.
  - dbg_data = reg[dbg_addr], with 0 for index 0.
- Simultaneous events:
  - rs_addr==rt_addr==wr_addr: both ports return wr_data.
  - wr_en=1 with wr_addr==0: no bypass, ports read 0.
  - BYPASS_EN=0: a same-cycle read returns the old value; the new value appears the next cycle.
- No stall or handshake: a write is always accepted in one cycle. The write-back stage never back-pressures.
- Unknown wr_addr with wr_en=0 must not alter state.

Decomposition:
- Shared defs file (alongside existing WB_* and PC_WIDTH defines):
  - REG_ADDR_WIDTH = 5.
  - REG_COUNT = 32.
  - REG_ZERO = 5'd0.
  - REG_DATA_WIDTH = 32.
- Sub-module reg_read_port, instantiated twice (rs, rt).
  - Inputs: addr, storage word, wr_en, wr_addr, wr_data, rst_n.
  - Implements the zero-register check plus bypass mux.
- The debug port uses the storage array directly.

Test Plan:
- Reset:
  - Stimulus: pulse rst_n low mid-cycle after writing reg[5]=32'hDEAD_BEEF.
  - Response: immediately dbg_data(5)=0, rs_data=0, wr_count=0, with no clock edge required.
- Basic write/read:
  - Stimulus: wr_en=1, wr_addr=3, wr_data=32'h1234_5678; next cycle wr_en=0, rs_addr=3.
  - Response: rs_data=32'h1234_5678, wr_count=1.
- Zero register:
  - Stimulus: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF, rs_addr=0, rt_addr=0.
  - Response: same cycle and after, rs_data=rt_data=0, wr_count unchanged.
- Bypass:
  - Stimulus: reg[7]=32'hA; in one cycle wr_en=1, wr_addr=7, wr_data=32'hB, rs_addr=7, rt_addr=7.
  - Response: rs_data=rt_data=32'hB, dbg_data(7)=32'hA in that cycle, 32'hB next cycle.
  - Repeat with BYPASS_EN=0: rs_data=32'hA that cycle.
- Reset vs write collision:
  - Stimulus: rst_n low during a wr_en=1, wr_addr=9, wr_data=32'h55 edge.
  - Response: reg[9]=0 after release; first post-reset write is accepted.
- Counter saturation:
  - Stimulus: force/preload wr_count near 16'hFFFE, then issue 3 writes to reg[1].
  - Response: wr_count reads 16'hFFFF and stays there.
